// File: rtl/gcm_ctrl_pkg.sv
// Shared types and constants for the GCM stream sequencer.
// Passby fields are numbered from the MSB end: id in the top byte, block index just below it.
`timescale 1ns/1ps
package gcm_ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_TAG_WAIT,
      S_TAG_OUT
   } state_t;

   localparam int BLK_W   = 128;
   localparam int IV_W    = 96;
   localparam int SIZE_W  = 64;
   localparam int ID_W    = 8;
   localparam int IDX_W   = 16;
   localparam int ID_LSB  = BLK_W - ID_W;
   localparam int IDX_LSB = ID_LSB - IDX_W;

   function automatic logic [BLK_W-1:0] make_passby(input logic [ID_W-1:0]  id,
                                                    input logic [IDX_W-1:0] idx);
      logic [BLK_W-1:0] pb;
      pb = '0;
      pb[ID_LSB +: ID_W]   = id;
      pb[IDX_LSB +: IDX_W] = idx;
      return pb;
   endfunction
endpackage

// File: rtl/gcm_ret_fifo.sv
// First-word-fall-through return buffer for ciphertext blocks; head reads as zero when empty.
// Pushes while full are ignored here; the sequencer flags them.
`timescale 1ns/1ps
module gcm_ret_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 129
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/gcm_stream_ctrl.sv
// Feeds multi-block messages through a gcm_aes core and returns ciphertext and tag on valid/ready streams.
// Issue is credit-limited so the non-stallable core can never overflow the return FIFO.
`timescale 1ns/1ps
module gcm_stream_ctrl
   import gcm_ctrl_pkg::*;
#(
   parameter int INFLIGHT = 4,
   parameter int LEN_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [BLK_W-1:0]  cfg_key,
   input  logic [IV_W-1:0]   cfg_iv,
   input  logic [BLK_W-1:0]  cfg_aad,
   input  logic [SIZE_W-1:0] cfg_aad_size,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [ID_W-1:0]   cfg_msg_id,
   input  logic              pt_valid,
   output logic              pt_ready,
   input  logic [BLK_W-1:0]  pt_data,
   output logic              ct_valid,
   input  logic              ct_ready,
   output logic [BLK_W-1:0]  ct_data,
   output logic              ct_last,
   output logic              tag_valid,
   input  logic              tag_ready,
   output logic [BLK_W-1:0]  tag_data,
   output logic              busy,
   output logic              err,
   output logic              core_new,
   output logic [BLK_W-1:0]  core_key,
   output logic [IV_W-1:0]   core_iv,
   output logic [BLK_W-1:0]  core_aad,
   output logic [SIZE_W-1:0] core_aad_size,
   output logic [SIZE_W-1:0] core_plain_text_size,
   output logic [BLK_W-1:0]  core_plain_text,
   output logic [BLK_W-1:0]  core_passby_text,
   input  logic              core_cp_ready,
   input  logic [BLK_W-1:0]  core_cipher_text,
   input  logic [BLK_W-1:0]  core_passby_ret,
   input  logic              core_tag_ready,
   input  logic [BLK_W-1:0]  core_tag
);
   localparam int CW = $clog2(INFLIGHT) + 1;

   state_t           state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] issued;
   logic [LEN_W-1:0] returned;
   logic [LEN_W-1:0] returned_nxt;
   logic [ID_W-1:0]  msg_id;
   logic [CW-1:0]    credits;
   logic             rst_done;
   logic             cfg_fire;
   logic             pt_fire;
   logic             ct_fire;
   logic             ret_active;
   logic             ret_take;
   logic             ret_bad;
   logic             ret_last;
   logic             fifo_full;
   logic             fifo_empty;
   logic [BLK_W:0]   fifo_head;
   logic             unused_passby_tail;

   // cfg_ready is held low until the first clock after reset so every output reads 0 in reset.
   assign cfg_ready  = rst_done && (state == S_IDLE);
   assign pt_ready   = (state == S_STREAM) && (credits != '0);
   assign ct_valid   = !fifo_empty;
   assign ct_data    = fifo_head[BLK_W-1:0];
   assign ct_last    = fifo_head[BLK_W];
   assign tag_valid  = (state == S_TAG_OUT);
   assign busy       = (state != S_IDLE);
   assign core_plain_text_size = SIZE_W'({len, 7'd0});

   assign cfg_fire   = cfg_valid && cfg_ready;
   assign pt_fire    = pt_valid && pt_ready;
   assign ct_fire    = ct_valid && ct_ready;
   assign ret_active = (state == S_STREAM) || (state == S_DRAIN);
   assign ret_take   = core_cp_ready && ret_active;
   assign ret_bad    = (core_passby_ret[ID_LSB +: ID_W] != msg_id) ||
                       (core_passby_ret[IDX_LSB +: IDX_W] != IDX_W'(returned));
   assign ret_last   = (returned == len - 1'b1);
   assign returned_nxt = returned + LEN_W'(ret_take);
   assign unused_passby_tail = ^core_passby_ret[IDX_LSB-1:0];

   gcm_ret_fifo #(
      .DEPTH (INFLIGHT),
      .WIDTH (BLK_W + 1)
   ) u_ret_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ret_take),
      .push_data ({ret_last, core_cipher_text}),
      .pop       (ct_fire),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         rst_done         <= 1'b0;
         len              <= '0;
         issued           <= '0;
         returned         <= '0;
         msg_id           <= '0;
         credits          <= CW'(INFLIGHT);
         err              <= 1'b0;
         tag_data         <= '0;
         core_new         <= 1'b0;
         core_key         <= '0;
         core_iv          <= '0;
         core_aad         <= '0;
         core_aad_size    <= '0;
         core_plain_text  <= '0;
         core_passby_text <= '0;
      end else begin
         rst_done <= 1'b1;
         core_new <= pt_fire;

         if (pt_fire && !ct_fire)
            credits <= credits - 1'b1;
         else if (ct_fire && !pt_fire && credits < CW'(INFLIGHT))
            credits <= credits + 1'b1;

         if (pt_fire) begin
            core_plain_text  <= pt_data;
            core_passby_text <= make_passby(msg_id, IDX_W'(issued));
            issued           <= issued + 1'b1;
         end

         // A full FIFO at return time means the block is lost; it still counts toward the message.
         if (ret_take) begin
            returned <= returned_nxt;
            if (ret_bad || fifo_full) err <= 1'b1;
         end
         if (core_cp_ready && !ret_active) err <= 1'b1;
         if (core_tag_ready && state != S_TAG_WAIT) err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (cfg_fire) begin
                  if (cfg_len == '0) begin
                     err <= 1'b1;
                  end else begin
                     core_key      <= cfg_key;
                     core_iv       <= cfg_iv;
                     core_aad      <= cfg_aad;
                     core_aad_size <= cfg_aad_size;
                     len           <= cfg_len;
                     msg_id        <= cfg_msg_id;
                     issued        <= '0;
                     returned      <= '0;
                     state         <= S_STREAM;
                  end
               end
            end
            S_STREAM:   if (pt_fire && issued == len - 1'b1) state <= S_DRAIN;
            S_DRAIN:    if (returned_nxt == len) state <= S_TAG_WAIT;
            S_TAG_WAIT: begin
               if (core_tag_ready) begin
                  tag_data <= core_tag;
                  state    <= S_TAG_OUT;
               end
            end
            S_TAG_OUT:  if (tag_ready) state <= S_IDLE;
            default:    state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gcm_stream_ctrl.sv
// Directed bench for gcm_stream_ctrl with a 3-cycle core model (cipher = ~plaintext, passby echoed).
`timescale 1ns/1ps
module tb_gcm_stream_ctrl;
   localparam int INFLIGHT = 4;
   localparam int LEN_W    = 16;
   localparam logic [127:0] KEY  = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [95:0]  IV   = 96'hCAFEBABEFACEDBADDECAF888;
   localparam logic [127:0] AAD  = 128'hFEEDFACEDEADBEEFFEEDFACEDEADBEEF;
   localparam logic [63:0]  AADS = 64'd128;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cfg_valid, cfg_ready;
   logic [127:0]       cfg_key, cfg_aad;
   logic [95:0]        cfg_iv;
   logic [63:0]        cfg_aad_size;
   logic [LEN_W-1:0]   cfg_len;
   logic [7:0]         cfg_msg_id;
   logic               pt_valid, pt_ready;
   logic [127:0]       pt_data;
   logic               ct_valid, ct_ready, ct_last;
   logic [127:0]       ct_data;
   logic               tag_valid, tag_ready;
   logic [127:0]       tag_data;
   logic               busy, err;
   logic               core_new;
   logic [127:0]       core_key, core_aad, core_plain_text, core_passby_text;
   logic [95:0]        core_iv;
   logic [63:0]        core_aad_size, core_plain_text_size;
   logic               core_cp_ready = 1'b0;
   logic [127:0]       core_cipher_text = '0;
   logic [127:0]       core_passby_ret = '0;
   logic               core_tag_ready;
   logic [127:0]       core_tag;

   always #5 clk = ~clk;

   gcm_stream_ctrl #(.INFLIGHT(INFLIGHT), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
      .cfg_aad(cfg_aad), .cfg_aad_size(cfg_aad_size), .cfg_len(cfg_len), .cfg_msg_id(cfg_msg_id),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
      .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
      .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_data(tag_data),
      .busy(busy), .err(err),
      .core_new(core_new), .core_key(core_key), .core_iv(core_iv), .core_aad(core_aad),
      .core_aad_size(core_aad_size), .core_plain_text_size(core_plain_text_size),
      .core_plain_text(core_plain_text), .core_passby_text(core_passby_text),
      .core_cp_ready(core_cp_ready), .core_cipher_text(core_cipher_text),
      .core_passby_ret(core_passby_ret), .core_tag_ready(core_tag_ready), .core_tag(core_tag)
   );

   // Core model plus monitor, all sampled on the falling edge.
   logic         model_en = 1'b1;
   logic         man_vld = 1'b0;
   logic [127:0] man_ct = '0, man_pb = '0;
   logic [2:0]   p_vld = '0;
   logic [127:0] p_ct [3];
   logic [127:0] p_pb [3];
   int           cyc = 0, cp_cnt = 0;
   int           new_cyc [$];
   logic [127:0] new_pb [$];
   logic [128:0] ct_q [$];

   always @(negedge clk) begin
      cyc++;
      if (core_new) begin
         new_cyc.push_back(cyc);
         new_pb.push_back(core_passby_text);
      end
      if (ct_valid && ct_ready) ct_q.push_back({ct_last, ct_data});
      if (!rst_n) begin
         p_vld = '0;
         core_cp_ready = 1'b0;
      end else if (model_en) begin
         core_cp_ready    = p_vld[2];
         core_cipher_text = p_ct[2];
         core_passby_ret  = p_pb[2];
         p_vld = {p_vld[1:0], core_new};
         p_ct[2] = p_ct[1]; p_ct[1] = p_ct[0]; p_ct[0] = ~core_plain_text;
         p_pb[2] = p_pb[1]; p_pb[1] = p_pb[0]; p_pb[0] = core_passby_text;
      end else begin
         core_cp_ready    = man_vld;
         core_cipher_text = man_ct;
         core_passby_ret  = man_pb;
      end
      if (core_cp_ready) cp_cnt++;
   end

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2) step();
   endtask

   task automatic cfg_send(input logic [LEN_W-1:0] len, input logic [7:0] id);
      cfg_valid = 1'b1; cfg_len = len; cfg_msg_id = id;
      cfg_key = KEY; cfg_iv = IV; cfg_aad = AAD; cfg_aad_size = AADS;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic send(input int n, input logic [127:0] base);
      int   sent = 0;
      int   guard = 0;
      logic fire;
      pt_valid = 1'b1;
      pt_data  = base;
      while (sent < n && guard < 300) begin
         @(negedge clk);
         fire = pt_ready;
         step();
         guard++;
         if (fire) begin
            sent++;
            pt_data = base + 128'(sent);
         end
      end
      pt_valid = 1'b0;
      check("send_count", 128'(sent), 128'(n));
   endtask

   task automatic wait_cp(input int target);
      int guard = 0;
      while (cp_cnt < target && guard < 300) begin
         step();
         guard++;
      end
      check("wait_core_return", 128'(cp_cnt >= target), 128'd1);
   endtask

   task automatic wait_ct(input int target);
      int guard = 0;
      while (ct_q.size() < target && guard < 300) begin
         step();
         guard++;
      end
      check("wait_ct_count", 128'(ct_q.size()), 128'(target));
   endtask

   task automatic finish_tag(input logic [127:0] tv, input int cp_target);
      wait_cp(cp_target);
      step();
      core_tag = tv; core_tag_ready = 1'b1;
      step();
      core_tag_ready = 1'b0;
      check("tag_valid", 128'(tag_valid), 128'd1);
      check("tag_data", tag_data, tv);
      tag_ready = 1'b1;
      step();
      tag_ready = 1'b0;
      check("tag_done_idle", 128'(busy), 128'd0);
   endtask

   typedef struct {
      logic [127:0] pt;
      logic [127:0] ct;
      logic [127:0] pb;
      logic         last;
   } vec_t;
   vec_t tbl [4];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cp_base, ct_base, nb, cnt;
      logic fire;
      logic [127:0] b2;

      tbl[0] = '{128'h00000000000000000000000000000001, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE, {8'h5A, 16'd0, 104'd0}, 1'b0};
      tbl[1] = '{128'h0123456789ABCDEF0011223344556677, 128'hFEDCBA9876543210FFEEDDCCBBAA9988, {8'h5A, 16'd1, 104'd0}, 1'b0};
      tbl[2] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'h00000000000000000000000000000000, {8'h5A, 16'd2, 104'd0}, 1'b0};
      tbl[3] = '{128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, {8'h5A, 16'd3, 104'd0}, 1'b1};

      rst_n = 1'b0; cfg_valid = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_aad = '0; cfg_aad_size = '0;
      cfg_len = '0; cfg_msg_id = '0; pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b1;
      tag_ready = 1'b0; core_tag_ready = 1'b0; core_tag = '0;

      // Reset state
      #12;
      check("rst_cfg_ready", 128'(cfg_ready), 128'd0);
      check("rst_flags", 128'({busy, err, ct_valid, tag_valid, pt_ready, core_new}), 128'd0);
      rst_n = 1'b1;
      repeat (2) step();
      check("post_rst_cfg_ready", 128'(cfg_ready), 128'd1);

      // Four-block message, table driven, ct_ready=1
      cp_base = cp_cnt; ct_base = ct_q.size(); nb = new_cyc.size();
      cfg_send(16'd4, 8'h5A);
      check("t1_busy", 128'(busy), 128'd1);
      check("t1_pt_size", 128'(core_plain_text_size), 128'd512);
      check("t1_key", core_key, KEY);
      check("t1_iv", 128'(core_iv), 128'(IV));
      check("t1_aad", core_aad, AAD);
      check("t1_aad_size", 128'(core_aad_size), 128'(AADS));
      pt_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pt_data = tbl[i].pt;
         check($sformatf("t1_pt_ready%0d", i), 128'(pt_ready), 128'd1);
         step();
      end
      pt_valid = 1'b0;
      wait_ct(ct_base + 4);
      check("t1_new_count", 128'(new_cyc.size() - nb), 128'd4);
      for (int i = 0; i < 4; i++) begin
         if (i > 0)
            check($sformatf("t1_new_gap%0d", i), 128'(new_cyc[nb+i] - new_cyc[nb+i-1]), 128'd1);
         check($sformatf("t1_passby%0d", i), new_pb[nb+i], tbl[i].pb);
         check($sformatf("t1_ct%0d", i), ct_q[ct_base+i][127:0], tbl[i].ct);
         check($sformatf("t1_last%0d", i), 128'(ct_q[ct_base+i][128]), 128'(tbl[i].last));
      end
      finish_tag(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, cp_base + 4);
      check("t1_err", 128'(err), 128'd0);

      // Backpressure: ct_ready low for 20 cycles
      b2 = 128'h1000;
      ct_ready = 1'b0;
      cp_base = cp_cnt; ct_base = ct_q.size();
      cfg_send(16'd6, 8'h11);
      pt_valid = 1'b1; pt_data = b2; cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         fire = pt_ready;
         step();
         if (fire) begin
            cnt++;
            pt_data = b2 + 128'(cnt);
         end
      end
      pt_valid = 1'b0;
      check("t2_issued_stalled", 128'(cnt), 128'd4);
      check("t2_pt_ready_low", 128'(pt_ready), 128'd0);
      check("t2_ct_valid", 128'(ct_valid), 128'd1);
      check("t2_no_overflow_err", 128'(err), 128'd0);
      ct_ready = 1'b1;
      send(2, b2 + 128'd4);
      wait_ct(ct_base + 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t2_ct%0d", i), ct_q[ct_base+i][127:0], ~(b2 + 128'(i)));
         check($sformatf("t2_last%0d", i), 128'(ct_q[ct_base+i][128]), 128'(i == 5));
      end
      finish_tag(128'h22, cp_base + 6);
      check("t2_err", 128'(err), 128'd0);

      // Zero-length configuration
      cfg_send(16'd0, 8'h20);
      check("t3_err_set", 128'(err), 128'd1);
      check("t3_busy", 128'(busy), 128'd0);
      check("t3_cfg_ready", 128'(cfg_ready), 128'd1);
      cp_base = cp_cnt; ct_base = ct_q.size();
      cfg_send(16'd1, 8'h22);
      check("t3_next_cfg_busy", 128'(busy), 128'd1);
      send(1, 128'h3333);
      wait_ct(ct_base + 1);
      check("t3_ct", 128'(ct_q[ct_base]), {1'b1, ~128'h3333});
      finish_tag(128'h33, cp_base + 1);
      check("t3_err_sticky", 128'(err), 128'd1);

      // Out-of-order return: index 2 before index 1
      apply_reset();
      check("t4_err_cleared", 128'(err), 128'd0);
      model_en = 1'b0;
      cfg_send(16'd3, 8'h33);
      send(3, 128'h4444);
      man_vld = 1'b1; man_ct = 128'hA0; man_pb = {8'h33, 16'd0, 104'd0};
      step();
      check("t4_in_order_ok", 128'(err), 128'd0);
      man_pb = {8'h33, 16'd2, 104'd0};
      step();
      check("t4_mismatch_err", 128'(err), 128'd1);
      man_pb = {8'h33, 16'd1, 104'd0};
      step();
      man_vld = 1'b0;
      step();

      // Reset in DRAIN with two blocks buffered
      apply_reset();
      model_en = 1'b1;
      ct_ready = 1'b0;
      cp_base = cp_cnt;
      cfg_send(16'd4, 8'h44);
      send(4, 128'h5555);
      wait_cp(cp_base + 2);
      check("t5_drain_busy", 128'({busy, pt_ready, ct_valid}), 128'b101);
      rst_n = 1'b0;
      #1;
      check("t5_rst_flags", 128'({cfg_ready, pt_ready, ct_valid, ct_last, tag_valid, busy, err, core_new}), 128'd0);
      check("t5_rst_ct_data", ct_data, 128'd0);
      check("t5_rst_core_text", core_plain_text | core_passby_text | core_key, 128'd0);
      check("t5_rst_sizes", 128'(core_plain_text_size | core_aad_size), 128'd0);
      check("t5_rst_tag", tag_data, 128'd0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2) step();
      check("t5_cfg_ready", 128'(cfg_ready), 128'd1);
      check("t5_credits", 128'(dut.credits), 128'(INFLIGHT));
      check("t5_fifo_empty", 128'(ct_valid), 128'd0);

      // Tag held under tag_ready=0; new cfg blocked meanwhile
      ct_ready = 1'b1;
      cp_base = cp_cnt;
      cfg_send(16'd1, 8'h66);
      send(1, 128'h6666);
      wait_cp(cp_base + 1);
      step();
      core_tag = 128'hABCDEF0123456789ABCDEF0123456789; core_tag_ready = 1'b1;
      step();
      core_tag_ready = 1'b0; core_tag = '0;
      cfg_valid = 1'b1; cfg_len = 16'd2; cfg_msg_id = 8'h77;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("t6_tag_valid%0d", c), 128'(tag_valid), 128'd1);
         check($sformatf("t6_tag_data%0d", c), tag_data, 128'hABCDEF0123456789ABCDEF0123456789);
         check($sformatf("t6_cfg_blocked%0d", c), 128'(cfg_ready), 128'd0);
         step();
      end
      tag_ready = 1'b1;
      step();
      tag_ready = 1'b0;
      check("t6_cfg_ready_after_tag", 128'(cfg_ready), 128'd1);
      step();
      cfg_valid = 1'b0;
      check("t6_next_cfg_busy", 128'(busy), 128'd1);
      check("t6_next_pt_size", 128'(core_plain_text_size), 128'd256);
      check("t6_err", 128'(err), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
